wait_sched: RTL and testbench
=============================

# wait_sched

Hardware scheduler for level-sensitive wait conditions (`wait(expr)`-style) shared among up to NWAIT suspended requesters. It sits between the process-suspend logic and a bank of watched variables. Each requester posts a comparison against the watched variables into its slot. The block re-evaluates every armed slot each cycle and issues wake events one at a time, in round-robin order, over a valid/ready handshake.

## Interface
- NWAIT, 4: number of waiter slots (2..16)
- NVAR, 3: number of watched variables
- DW, 32: variable/immediate width; all compares are signed
- TOW, 16: timeout counter width (used only with timeout feature)

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- var_i  in  NVAR*DW  watched values, packed, var k at [k*DW +: DW]
- post_valid  in  1  new wait request
- post_ready  out  1  slot post_id is IDLE
- post_id  in  $clog2(NWAIT)  target slot
- post_lhs  in  $clog2(NVAR)  left operand variable index
- post_rhs_imm  in  1  1: right operand is post_imm; 0: variable post_rhs
- post_rhs  in  $clog2(NVAR)  right operand variable index
- post_imm  in  DW  immediate right operand
- post_op  in  3  0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE; 6/7 treated as never-true
- cancel_valid  in  1  cancel request
- cancel_id  in  $clog2(NWAIT)  slot to cancel
- wake_valid  out  1  wake event pending
- wake_ready  in  1  consumer accepts wake
- wake_id  out  $clog2(NWAIT)  slot being woken
- post_timeout  in  TOW  cycles before forced wake, 0 = none (timeout feature only)
- wake_timeout  out  1  wake caused by timeout (timeout feature only)

## Operation
- Per-slot FSM: IDLE → ARMED → PENDING → GRANTED → IDLE.
- IDLE: post accepted when post_valid && post_ready. Stores lhs, rhs_sel, rhs, imm, and op. Moves to ARMED.
- ARMED: each cycle, compute cond = var[lhs] op (rhs_imm ? imm : var[rhs]), signed DW-bit compare, no extension. cond true → PENDING at next edge. A condition already true when the slot arms still wakes; this is level semantics.
- PENDING is sticky: once latched, later changes in var_i do not revert it.
- Arbiter: when the output register is empty, or is being emptied this cycle (wake_valid && wake_ready), select the first PENDING slot at or after rr_ptr (wrapping). Load wake_id and set wake_valid. That slot moves to GRANTED. rr_ptr = selected+1 mod NWAIT.
- GRANTED → IDLE on wake handshake.
- wake_id and wake_timeout are held stable while wake_valid && !wake_ready.
- Cancel: an ARMED or PENDING slot goes to IDLE next edge. Cancel on an IDLE or GRANTED slot is ignored.
- Cancel and post to the same IDLE slot in the same cycle: the post wins.

## Timing
- Reset values: all slots IDLE, rr_ptr=0, wake_valid=0, wake_id=0, wake_timeout=0. post_ready reflects slot state combinationally, so it is 1 after reset.
- Minimum post→wake_valid latency is 3 cycles, condition true at arm:
  - edge T+1: ARMED
  - edge T+2: PENDING
  - edge T+3: wake_valid
- Back-to-back wakes run at 1 per cycle while wake_ready=1.
- post_ready is combinational from slot state. The other outputs are registered.
- rst_n low mid-operation discards all slots and any held wake immediately. No wake is issued for discarded slots.

## Configuration
- WAIT_SCHED_TIMEOUT_EN defined:
  - post_timeout and wake_timeout ports exist.
  - Each slot has a TOW-bit down-counter loaded at post.
  - The counter decrements while ARMED. When it reaches 1, the slot goes to PENDING with a timeout flag, unless cond is true that cycle; cond true has priority and clears the flag.
  - post_timeout=0 never times out.
- Undefined: ports, counters and flag absent. Slots stay ARMED until cond is true or the slot is cancelled.

## Structure
- Package wait_sched_pkg holds:
  - slot state enum
  - op encoding localparams
  - slot record typedef (lhs, rhs_sel, rhs, imm, op, timeout count, flag)
- Sub-module wait_sched_cmp: a combinational signed comparator, one instance per slot.
- Top holds the slot FSMs, the round-robin arbiter and the output register.

## Test plan
- Scenario 1, vars (a,b,c)=(0,0,0):
  - Stimulus: post slot0 a==2, then set a=2 five cycles later.
  - Response: wake_id=0 exactly 3 cycles after a changes.
  - Stimulus: repost slot0 a<2.
  - Response: immediate wake at 3 cycles.
- Scenario 2, var–var compare:
  - Stimulus: post slot1 b>a with a=2, b=0; set b=2 (no wake), then a=1.
  - Response: wake follows the a=1 update.
- Scenario 3, round-robin:
  - Stimulus: arm all 4 slots with a==7, hold wake_ready=0, then set a=7.
  - Response: wake_id stable at 0. With wake_ready=1, ids 0,1,2,3 on consecutive cycles.
  - Stimulus: repeat the sequence.
  - Response: the order starts at 0 again, since rr_ptr wrapped to 0.
- Scenario 4, cancel and sticky PENDING:
  - Stimulus: cancel ARMED slot2.
  - Response: no wake; post_ready for id 2 returns to 1.
  - Stimulus: pulse a condition true for 1 cycle.
  - Response: the wake still occurs.
- Scenario 5, reset:
  - Stimulus: assert rst_n while wake_valid=1 and two slots are PENDING.
  - Response: all outputs return to reset values; no wakes after release.
- Scenario 6 (WAIT_SCHED_TIMEOUT_EN), timeout:
  - Stimulus: post a==9 with post_timeout=5.
  - Response: wake with wake_timeout=1.
  - Stimulus: same post, with cond true on the expiry cycle.
  - Response: wake_timeout=0.

Source files
------------

// File: rtl/wait_sched_pkg.sv
// wait_sched_pkg: shared types and constants for the wait-condition scheduler.
// Optional feature macro: WAIT_SCHED_TIMEOUT_EN adds per-slot timeout state.
package wait_sched_pkg;

    // Watched-variable bank geometry and timeout counter width.
    localparam int NVAR = 3;
    localparam int DW   = 32;
    localparam int TOW  = 16;
    localparam int VW   = (NVAR > 1) ? $clog2(NVAR) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_PENDING = 2'd2,
        S_GRANTED = 2'd3
    } slot_state_e;

    typedef logic [2:0] op_t;

    localparam op_t OP_EQ = 3'd0;
    localparam op_t OP_NE = 3'd1;
    localparam op_t OP_LT = 3'd2;
    localparam op_t OP_LE = 3'd3;
    localparam op_t OP_GT = 3'd4;
    localparam op_t OP_GE = 3'd5;

    // One posted wait condition. rhs_sel=1 selects imm as the right operand.
    typedef struct packed {
        logic [VW-1:0]  lhs;
        logic           rhs_sel;
        logic [VW-1:0]  rhs;
        logic [DW-1:0]  imm;
        op_t            op;
`ifdef WAIT_SCHED_TIMEOUT_EN
        logic [TOW-1:0] tmo;
        logic           tflag;
`endif
    } slot_t;

endpackage

// File: rtl/wait_sched_cmp.sv
// wait_sched_cmp: combinational signed comparator evaluating one slot's condition.
module wait_sched_cmp
    import wait_sched_pkg::*;
(
    input  logic [DW-1:0] lhs,
    input  logic [DW-1:0] rhs,
    input  op_t           op,
    output logic          hit
);

    // Evaluate lhs op rhs as signed DW-bit values; encodings 6 and 7 never match.
    always_comb begin
        // NOTE: hit gets a value before the case so no path can leave it unassigned and infer a latch.
        hit = 1'b0;
        case (op)
            OP_EQ:   hit = ($signed(lhs) == $signed(rhs));
            OP_NE:   hit = ($signed(lhs) != $signed(rhs));
            OP_LT:   hit = ($signed(lhs) <  $signed(rhs));
            OP_LE:   hit = ($signed(lhs) <= $signed(rhs));
            OP_GT:   hit = ($signed(lhs) >  $signed(rhs));
            OP_GE:   hit = ($signed(lhs) >= $signed(rhs));
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/wait_sched.sv
// wait_sched: level-sensitive wait-condition scheduler with round-robin wake arbitration.
// Optional feature macro: WAIT_SCHED_TIMEOUT_EN (post_timeout/wake_timeout, per-slot timeout).
module wait_sched
    import wait_sched_pkg::*;
#(
    parameter  int NWAIT = 4,
    localparam int IW    = $clog2(NWAIT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NVAR*DW-1:0] var_i,
    input  logic               post_valid,
    output logic               post_ready,
    input  logic [IW-1:0]      post_id,
    input  logic [VW-1:0]      post_lhs,
    input  logic               post_rhs_imm,
    input  logic [VW-1:0]      post_rhs,
    input  logic [DW-1:0]      post_imm,
    input  op_t                post_op,
`ifdef WAIT_SCHED_TIMEOUT_EN
    input  logic [TOW-1:0]     post_timeout,
    output logic               wake_timeout,
`endif
    input  logic               cancel_valid,
    input  logic [IW-1:0]      cancel_id,
    output logic               wake_valid,
    input  logic               wake_ready,
    output logic [IW-1:0]      wake_id
);

    slot_state_e         state_q [NWAIT];
    slot_t               slot_q  [NWAIT];
    logic [DW-1:0]       var_q   [NVAR];
    logic [DW-1:0]       lhs_val [NWAIT];
    logic [DW-1:0]       rhs_val [NWAIT];
    logic [NWAIT-1:0]    cond;
    logic [NWAIT-1:0]    expire;
    logic [NWAIT-1:0]    post_hit;
    logic [NWAIT-1:0]    cancel_hit;
    logic [IW-1:0]       rr_ptr;
    logic [IW-1:0]       sel_id;
    logic                sel_valid;
    logic                load;

    assign post_ready = (state_q[post_id] == S_IDLE);

    // Snapshot the watched variables so every slot compares against one aligned set of values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NVAR; k++) var_q[k] <= '0;
        end else begin
            // NOTE: state updates use <= so every register samples pre-edge values, whatever the statement order.
            for (int k = 0; k < NVAR; k++) var_q[k] <= var_i[k*DW +: DW];
        end
    end

    // Route each slot's operands from the snapshot (out-of-range indices read as zero).
    always_comb begin
        for (int i = 0; i < NWAIT; i++) begin
            lhs_val[i] = '0;
            rhs_val[i] = slot_q[i].rhs_sel ? slot_q[i].imm : '0;
            for (int k = 0; k < NVAR; k++) begin
                if (slot_q[i].lhs == VW'(k)) lhs_val[i] = var_q[k];
                if (!slot_q[i].rhs_sel && (slot_q[i].rhs == VW'(k))) rhs_val[i] = var_q[k];
            end
        end
    end

    for (genvar g = 0; g < NWAIT; g++) begin : g_slot
        wait_sched_cmp u_cmp (
            .lhs (lhs_val[g]),
            .rhs (rhs_val[g]),
            .op  (slot_q[g].op),
            .hit (cond[g])
        );
    end

    // Per-slot request decode and timeout expiry.
    always_comb begin
        for (int i = 0; i < NWAIT; i++) begin
            post_hit[i]   = post_valid && post_ready && (post_id == IW'(i));
            cancel_hit[i] = cancel_valid && (cancel_id == IW'(i));
`ifdef WAIT_SCHED_TIMEOUT_EN
            expire[i]     = (slot_q[i].tmo == TOW'(1));
`else
            expire[i]     = 1'b0;
`endif
        end
    end

    // Round-robin pick: first PENDING slot at or after rr_ptr; a slot being cancelled is skipped.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = '0;
        for (int off = NWAIT - 1; off >= 0; off--) begin
            if ((state_q[(int'(rr_ptr) + off) % NWAIT] == S_PENDING) &&
                !cancel_hit[(int'(rr_ptr) + off) % NWAIT]) begin
                sel_valid = 1'b1;
                sel_id    = IW'((int'(rr_ptr) + off) % NWAIT);
            end
        end
        load = sel_valid && (!wake_valid || wake_ready);
    end

    // Slot FSMs, round-robin pointer and the registered wake output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NWAIT; i++) state_q[i] <= S_IDLE;
            rr_ptr     <= '0;
            wake_valid <= 1'b0;
            wake_id    <= '0;
`ifdef WAIT_SCHED_TIMEOUT_EN
            wake_timeout <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < NWAIT; i++) begin
                case (state_q[i])
                    S_IDLE:    if (post_hit[i]) state_q[i] <= S_ARMED;
                    S_ARMED:   if (cancel_hit[i]) state_q[i] <= S_IDLE;
                               else if (cond[i] || expire[i]) state_q[i] <= S_PENDING;
                    S_PENDING: if (cancel_hit[i]) state_q[i] <= S_IDLE;
                               else if (load && (sel_id == IW'(i))) state_q[i] <= S_GRANTED;
                    S_GRANTED: if (wake_valid && wake_ready && (wake_id == IW'(i)))
                                   state_q[i] <= S_IDLE;
                    default:   state_q[i] <= S_IDLE;
                endcase
            end
            if (load) begin
                wake_valid <= 1'b1;
                wake_id    <= sel_id;
                rr_ptr     <= (sel_id == IW'(NWAIT - 1)) ? '0 : sel_id + IW'(1);
`ifdef WAIT_SCHED_TIMEOUT_EN
                wake_timeout <= slot_q[sel_id].tflag;
`endif
            end else if (wake_valid && wake_ready) begin
                wake_valid <= 1'b0;
            end
        end
    end

    // Slot payload: captured at post, timeout counter and flag maintained while ARMED.
    always_ff @(posedge clk) begin
        // NOTE: payload has no reset; it is only read once its slot leaves IDLE, which requires a fresh post.
        for (int i = 0; i < NWAIT; i++) begin
            if (post_hit[i]) begin
                slot_q[i].lhs     <= post_lhs;
                slot_q[i].rhs_sel <= post_rhs_imm;
                slot_q[i].rhs     <= post_rhs;
                slot_q[i].imm     <= post_imm;
                slot_q[i].op      <= post_op;
`ifdef WAIT_SCHED_TIMEOUT_EN
                slot_q[i].tmo     <= post_timeout;
                slot_q[i].tflag   <= 1'b0;
            end else if (state_q[i] == S_ARMED) begin
                // The flag ends up set only if the slot leaves ARMED by expiry with cond false.
                slot_q[i].tflag <= !cond[i];
                if (slot_q[i].tmo > TOW'(1)) slot_q[i].tmo <= slot_q[i].tmo - TOW'(1);
`endif
            end
        end
    end

endmodule

// File: tb/tb_wait_sched.sv
// tb_wait_sched: directed self-checking bench for wait_sched.
module tb_wait_sched;
    import wait_sched_pkg::*;

    localparam int NWAIT = 4;
    localparam int IW    = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [DW-1:0]      va, vb, vc;
    logic [NVAR*DW-1:0] var_i;
    logic               post_valid, post_ready, post_rhs_imm;
    logic [IW-1:0]      post_id, cancel_id, wake_id;
    logic [VW-1:0]      post_lhs, post_rhs;
    logic [DW-1:0]      post_imm;
    op_t                post_op;
    logic               cancel_valid, wake_valid, wake_ready;
`ifdef WAIT_SCHED_TIMEOUT_EN
    logic [TOW-1:0]     post_timeout;
    logic               wake_timeout;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    assign var_i = {vc, vb, va};

    always #5 clk = ~clk;

    wait_sched #(.NWAIT(NWAIT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .var_i        (var_i),
        .post_valid   (post_valid),
        .post_ready   (post_ready),
        .post_id      (post_id),
        .post_lhs     (post_lhs),
        .post_rhs_imm (post_rhs_imm),
        .post_rhs     (post_rhs),
        .post_imm     (post_imm),
        .post_op      (post_op),
`ifdef WAIT_SCHED_TIMEOUT_EN
        .post_timeout (post_timeout),
        .wake_timeout (wake_timeout),
`endif
        .cancel_valid (cancel_valid),
        .cancel_id    (cancel_id),
        .wake_valid   (wake_valid),
        .wake_ready   (wake_ready),
        .wake_id      (wake_id)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle post; returns just after the edge that accepts it.
    task automatic post(input int id, input int lhs, input bit rimm, input int rhs,
                        input logic [DW-1:0] imm, input op_t op, input int tmo);
        post_valid   = 1'b1;
        post_id      = IW'(id);
        post_lhs     = VW'(lhs);
        post_rhs_imm = rimm;
        post_rhs     = VW'(rhs);
        post_imm     = imm;
        post_op      = op;
`ifdef WAIT_SCHED_TIMEOUT_EN
        post_timeout = TOW'(tmo);
`endif
        step(1);
        post_valid = 1'b0;
    endtask

    task automatic cancel(input int id);
        cancel_valid = 1'b1;
        cancel_id    = IW'(id);
        step(1);
        cancel_valid = 1'b0;
    endtask

    // n cycles in which no wake may be presented.
    task automatic quiet(input string tag, input int n);
        logic saw;
        saw = 1'b0;
        repeat (n) begin
            step(1);
            saw = saw | wake_valid;
        end
        check(tag, saw, 1'b0);
    endtask

    // Arm all slots on a==7, hold the consumer off, then drain; expects ids 0..3.
    task automatic run_rr(input string tag);
        va = '0;
        wake_ready = 1'b0;
        step(2);
        for (int i = 0; i < NWAIT; i++) post(i, 0, 1'b1, 0, 7, OP_EQ, 0);
        va = 7;
        step(3);
        check({tag, "_first_valid"}, wake_valid, 1'b1);
        check({tag, "_first_id"}, wake_id, 0);
        step(3);
        check({tag, "_held_valid"}, wake_valid, 1'b1);
        check({tag, "_held_id"}, wake_id, 0);
        wake_ready = 1'b1;
        for (int k = 1; k < NWAIT; k++) begin
            step(1);
            check({tag, "_seq_valid"}, wake_valid, 1'b1);
            check({tag, "_seq_id"}, wake_id, k);
        end
        step(1);
        check({tag, "_drained"}, wake_valid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        va = '0; vb = '0; vc = '0;
        post_valid = 1'b0; post_id = '0; post_lhs = '0; post_rhs_imm = 1'b0;
        post_rhs = '0; post_imm = '0; post_op = OP_EQ;
        cancel_valid = 1'b0; cancel_id = '0; wake_ready = 1'b1;
`ifdef WAIT_SCHED_TIMEOUT_EN
        post_timeout = '0;
`endif
        step(2);
        rst_n = 1'b1;
        step(1);

        // Reset state.
        check("rst_wake_valid", wake_valid, 1'b0);
        check("rst_wake_id", wake_id, 0);
        check("rst_post_ready", post_ready, 1'b1);
`ifdef WAIT_SCHED_TIMEOUT_EN
        check("rst_wake_timeout", wake_timeout, 1'b0);
`endif

        // Scenario 1: a==2 armed, a set later; then a<2 already true.
        post(0, 0, 1'b1, 0, 2, OP_EQ, 0);
        check("s1_busy_ready", post_ready, 1'b0);
        quiet("s1_no_early_wake", 5);
        va = 2;
        step(2);
        check("s1_not_yet", wake_valid, 1'b0);
        step(1);
        check("s1_wake_valid", wake_valid, 1'b1);
        check("s1_wake_id", wake_id, 0);
        step(1);
        check("s1_handshake_clears", wake_valid, 1'b0);
        check("s1_slot_idle", post_ready, 1'b1);
        va = 0;
        step(2);
        post(0, 0, 1'b1, 0, 2, OP_LT, 0);
        step(1);
        check("s1_imm_not_yet", wake_valid, 1'b0);
        step(1);
        check("s1_imm_wake_valid", wake_valid, 1'b1);
        check("s1_imm_wake_id", wake_id, 0);
        step(1);

        // Scenario 2: b > a against a variable right operand.
        va = 2; vb = 0;
        step(2);
        post(1, 1, 1'b0, 0, 0, OP_GT, 0);
        quiet("s2_b_below_a", 3);
        vb = 2;
        quiet("s2_b_equal_a", 3);
        va = 1;
        step(2);
        check("s2_not_yet", wake_valid, 1'b0);
        step(1);
        check("s2_wake_valid", wake_valid, 1'b1);
        check("s2_wake_id", wake_id, 1);
        step(1);

        // Signed compare: -1 < 1 must hold.
        va = 32'hFFFF_FFFF;
        step(2);
        post(3, 0, 1'b1, 0, 1, OP_LT, 0);
        step(2);
        check("s2_signed_valid", wake_valid, 1'b1);
        check("s2_signed_id", wake_id, 3);
        step(1);

        // Scenario 4: cancel, sticky PENDING, post beating cancel, never-true op.
        va = 0;
        step(2);
        post(2, 0, 1'b1, 0, 7, OP_EQ, 0);
        step(1);
        cancel(2);
        post_id = 2'd2;
        check("s4_cancel_ready", post_ready, 1'b1);
        va = 7;
        quiet("s4_cancelled_no_wake", 5);
        va = 0;
        step(2);
        post(2, 0, 1'b1, 0, 5, OP_EQ, 0);
        step(2);
        va = 5;
        step(1);
        va = 0;
        step(1);
        check("s4_sticky_not_yet", wake_valid, 1'b0);
        step(1);
        check("s4_sticky_valid", wake_valid, 1'b1);
        check("s4_sticky_id", wake_id, 2);
        step(1);
        cancel_valid = 1'b1;
        cancel_id    = 2'd3;
        post(3, 0, 1'b1, 0, 0, OP_EQ, 0);
        cancel_valid = 1'b0;
        check("s4_post_beats_cancel", post_ready, 1'b0);
        step(2);
        check("s4_pc_valid", wake_valid, 1'b1);
        check("s4_pc_id", wake_id, 3);
        step(1);
        post(0, 0, 1'b1, 0, 0, 3'd6, 0);
        quiet("s4_op6_never", 5);
        post_id = 2'd0;
        check("s4_op6_still_armed", post_ready, 1'b0);
        cancel(0);
        check("s4_op6_cancelled", post_ready, 1'b1);

        // Scenario 3: round-robin order, held output, pointer wrap.
        run_rr("s3a");
        run_rr("s3b");

        // Scenario 5: reset while a wake is held and two slots are PENDING.
        va = 0;
        wake_ready = 1'b0;
        step(2);
        post(0, 0, 1'b1, 0, 3, OP_EQ, 0);
        post(1, 0, 1'b1, 0, 3, OP_EQ, 0);
        post(2, 0, 1'b1, 0, 3, OP_EQ, 0);
        va = 3;
        step(3);
        check("s5_pre_valid", wake_valid, 1'b1);
        rst_n = 1'b0;
        #2;
        check("s5_rst_valid", wake_valid, 1'b0);
        check("s5_rst_id", wake_id, 0);
        check("s5_rst_ready", post_ready, 1'b1);
`ifdef WAIT_SCHED_TIMEOUT_EN
        check("s5_rst_timeout", wake_timeout, 1'b0);
`endif
        step(1);
        rst_n = 1'b1;
        wake_ready = 1'b1;
        quiet("s5_no_wake_after_reset", 10);

`ifdef WAIT_SCHED_TIMEOUT_EN
        // Scenario 6: timeout expiry, cond on the expiry cycle, zero timeout.
        va = 0;
        step(2);
        post(0, 0, 1'b1, 0, 9, OP_EQ, 5);
        step(5);
        check("s6_to_not_yet", wake_valid, 1'b0);
        step(1);
        check("s6_to_valid", wake_valid, 1'b1);
        check("s6_to_flag", wake_timeout, 1'b1);
        step(1);
        post(0, 0, 1'b1, 0, 9, OP_EQ, 5);
        step(3);
        va = 9;
        step(2);
        check("s6_race_not_yet", wake_valid, 1'b0);
        step(1);
        check("s6_race_valid", wake_valid, 1'b1);
        check("s6_race_flag", wake_timeout, 1'b0);
        step(1);
        va = 0;
        step(2);
        post(0, 0, 1'b1, 0, 9, OP_EQ, 0);
        quiet("s6_zero_never", 20);
        cancel(0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
